// File: rtl/code_sequencer_if.sv
// Control, storage-write and status bundle between a host (master) and code_sequencer (slave).
interface code_sequencer_if #(
    parameter int code_size  = 12,
    parameter int loop_depth = 4
);
    logic                            start;
    logic                            active;
    logic [31:0]                     program_length;
    logic                            wrap_mode;
    logic                            jump;
    logic [31:0]                     jump_target;
    logic                            loop_begin;
    logic [15:0]                     loop_count;
    logic                            loop_end;
    logic                            is_write;
    logic [31:0]                     write_line;
    logic [code_size-1:0]            write_data;
    logic [code_size-1:0]            code;
    logic [31:0]                     code_index;
    logic                            running;
    logic                            done;
    logic [$clog2(loop_depth+1)-1:0] loop_level;
    logic                            error;

    modport master (
        output start, active, program_length, wrap_mode, jump, jump_target,
               loop_begin, loop_count, loop_end, is_write, write_line, write_data,
        input  code, code_index, running, done, loop_level, error
    );

    modport slave (
        input  start, active, program_length, wrap_mode, jump, jump_target,
               loop_begin, loop_count, loop_end, is_write, write_line, write_data,
        output code, code_index, running, done, loop_level, error
    );
endinterface

// File: rtl/code_sequencer.sv
// Steps through a stored program line by line, with jumps, nested counted loops,
// optional wrap-around and a fault pulse for every illegal request.
module code_sequencer #(
    parameter int code_size     = 12,
    parameter int max_code_line = 128,
    parameter int loop_depth    = 4
) (
    input logic             clk,
    input logic             reset,
    code_sequencer_if.slave bus
);
    localparam int aw = (max_code_line > 1) ? $clog2(max_code_line) : 1;
    localparam int lw = $clog2(loop_depth + 1);
    localparam int iw = (loop_depth > 1) ? $clog2(loop_depth) : 1;
    localparam logic [lw-1:0] full_level = lw'(loop_depth);
    localparam logic [31:0]   line_limit = 32'(max_code_line);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [31:0]     index_q, index_n;
    logic [31:0]     length_q, length_n;
    logic            wrap_q, wrap_n;
    logic [lw-1:0]   level_q, level_n;
    logic            error_q, error_n;

    // NOTE: storage is preset at power-up only; neither it nor the loop stack
    // sits under reset, since the occupancy counter alone defines which entries are live.
    logic [code_size-1:0] mem [max_code_line] = '{default: '0};
    logic [31:0]          stk_start  [loop_depth];
    logic [15:0]          stk_remain [loop_depth];

    logic [iw-1:0] top_idx;
    logic [31:0]   top_start;
    logic [15:0]   top_remain;

    logic          stk_we;
    logic [iw-1:0] stk_idx;
    logic [31:0]   stk_wstart;
    logic [15:0]   stk_wremain;

    logic          advance;
    logic          write_bad;
    logic          write_ok;

    assign write_bad = bus.is_write && (bus.write_line >= line_limit);
    assign write_ok  = bus.is_write && (bus.write_line <  line_limit);

    assign top_idx    = iw'(level_q - lw'(1));
    assign top_start  = stk_start[top_idx];
    assign top_remain = stk_remain[top_idx];

    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        index_n     = index_q;
        length_n    = length_q;
        wrap_n      = wrap_q;
        level_n     = level_q;
        error_n     = write_bad;
        stk_we      = 1'b0;
        stk_idx     = top_idx;
        stk_wstart  = top_start;
        stk_wremain = top_remain;
        advance     = 1'b0;

        if (bus.start) begin
            length_n = bus.program_length;
            wrap_n   = bus.wrap_mode;
            index_n  = '0;
            level_n  = '0;
            if (bus.program_length == '0) begin
                state_n = DONE;
                error_n = 1'b1;
            end else begin
                state_n = RUN;
            end
        end else if (state == RUN && bus.active) begin
            if (bus.jump) begin
                if (bus.jump_target < length_q) begin
                    index_n = bus.jump_target;
                end else begin
                    state_n = DONE;
                    error_n = 1'b1;
                end
            end else begin
                advance = 1'b1;
                // loop_end resolves first; loop_begin only rides on a plain increment
                if (bus.loop_end) begin
                    if (level_q == '0) begin
                        error_n = 1'b1;
                    end else if (top_remain != '0) begin
                        advance     = 1'b0;
                        index_n     = top_start;
                        stk_we      = 1'b1;
                        stk_wremain = top_remain - 16'd1;
                    end else begin
                        level_n = level_q - lw'(1);
                    end
                end
                if (advance) begin
                    if (bus.loop_begin) begin
                        if (level_n == full_level || bus.loop_count == '0) begin
                            error_n = 1'b1;
                        end else begin
                            stk_we      = 1'b1;
                            stk_idx     = iw'(level_n);
                            stk_wstart  = index_q + 32'd1;
                            stk_wremain = bus.loop_count - 16'd1;
                            level_n     = level_n + lw'(1);
                        end
                    end
                    if (index_q == length_q - 32'd1) begin
                        if (wrap_q) begin
                            index_n = '0;
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        index_n = index_q + 32'd1;
                    end
                end
            end
        end
    end

    // NOTE: clocked blocks use <= so every register samples pre-edge values
    // regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            index_q  <= '0;
            length_q <= '0;
            wrap_q   <= 1'b0;
            level_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state    <= state_n;
            index_q  <= index_n;
            length_q <= length_n;
            wrap_q   <= wrap_n;
            level_q  <= level_n;
            error_q  <= error_n;
        end
    end

    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem[bus.write_line[aw-1:0]] <= bus.write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (stk_we) begin
            stk_start[stk_idx]  <= stk_wstart;
            stk_remain[stk_idx] <= stk_wremain;
        end
    end

    // Read-before-write: a write to the current line shows up from the next cycle.
    assign bus.code       = (index_q < line_limit) ? mem[index_q[aw-1:0]] : '0;
    assign bus.code_index = index_q;
    assign bus.running    = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.loop_level = level_q;
    assign bus.error      = error_q;
endmodule

// File: doc/code_sequencer.md
CODE_SEQUENCER -- requirements
Module: code_sequencer

Interface
REQ-001 SHALL have parameter code_size, default 12, meaning code word width in bits.
REQ-002 SHALL have parameter max_code_line, default 128, meaning storage depth; valid lines are 0..max_code_line-1.
REQ-003 SHALL have parameter loop_depth, default 4, meaning loop stack entries.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that launches execution at line 0.
REQ-007 SHALL have port active  in  1  advance enable for the current line.
REQ-008 SHALL have port program_length  in  32  number of valid lines, sampled on start.
REQ-009 SHALL have port wrap_mode  in  1  1 = wrap to line 0 after the last line; 0 = stop. Sampled on start.
REQ-010 SHALL have port jump  in  1  replace the next advance with a load of jump_target.
REQ-011 SHALL have port jump_target  in  32  jump destination line.
REQ-012 SHALL have port loop_begin  in  1  push a loop whose body starts at code_index+1.
REQ-013 SHALL have port loop_count  in  16  total loop iterations, N>=1.
REQ-014 SHALL have port loop_end  in  1  current line closes the innermost loop.
REQ-015 SHALL have ports is_write in 1, write_line in 32 and write_data in code_size, forming the storage write port.
REQ-016 SHALL have port code  out  code_size  storage[code_index], read combinationally.
REQ-017 SHALL have port code_index  out  32  current line.
REQ-018 SHALL have ports running out 1 and done out 1, both decoded from the state machine.
REQ-019 SHALL have port loop_level  out  $clog2(loop_depth+1)  current stack occupancy.
REQ-020 SHALL have port error  out  1  one-cycle pulse on any fault listed in this document.

Function
REQ-021 SHALL implement states IDLE, RUN and DONE; running=1 only in RUN and done=1 only in DONE.
REQ-022 SHALL, on start in any state, enter RUN, set code_index=0, clear the loop stack, and latch program_length and wrap_mode.
REQ-023 SHALL treat start with program_length==0 as a fault: go to DONE and pulse error.
REQ-024 SHALL, in RUN with active=0, hold code_index and ignore jump, loop_begin and loop_end.
REQ-025 SHALL, in RUN with active=1, resolve the next line using priority jump > loop_end > normal increment.
REQ-026 SHALL, on jump with jump_target<program_length, set code_index=jump_target; with jump_target>=program_length, go to DONE and pulse error.
REQ-027 SHALL, on loop_begin, push {start=code_index+1, remaining=loop_count-1} and then increment normally.
REQ-028 SHALL treat loop_begin with the stack full, or with loop_count==0, as a fault: no push, pulse error, increment normally.
REQ-029 SHALL, on loop_end with top remaining>0, decrement remaining and set code_index=top start.
REQ-030 SHALL, on loop_end with top remaining==0, pop the entry and increment normally.
REQ-031 SHALL treat loop_end with an empty stack as a fault: pulse error, increment normally.
REQ-032 SHALL, when both loop_begin and loop_end are asserted on one line, apply loop_end first and then apply loop_begin only if the resulting action is an increment.
REQ-033 SHALL define normal increment at code_index==program_length-1 as: wrap_mode=1 -> code_index=0 with the stack unchanged; wrap_mode=0 -> enter DONE with code_index held.
REQ-034 SHALL, in IDLE and DONE, hold code_index and ignore active.
REQ-035 SHALL perform a write of storage[write_line] at posedge when is_write=1 and write_line<max_code_line, in any state.
REQ-036 SHALL ignore a write with write_line>=max_code_line and pulse error.
REQ-037 SHALL, when a write targets the current line, keep the old data on code during that cycle and present the new data from the next cycle.
REQ-038 SHALL set storage contents to 0 at power-up only.

Reset
REQ-039 SHALL, on reset, force state=IDLE, code_index=0, loop_level=0, error=0, and restore the latched program_length and wrap_mode to defaults 0.
REQ-040 SHALL give reset priority over start, active, and all control inputs.
REQ-041 SHALL leave storage unaltered by reset, and SHALL still honour a valid write in the reset cycle.
REQ-042 SHALL, on reset asserted mid-RUN or mid-loop, discard all loop state with no error pulse.

Verification
REQ-043 SHALL cover: write lines 0..3 with values 5,6,7,8, start with program_length=4 and wrap_mode=0, active held high -> code reads 5,6,7,8, done=1 one cycle after line 3, code_index=3.
REQ-044 SHALL cover: the same program with wrap_mode=1 -> code_index sequence 0,1,2,3,0,1, and done stays 0.
REQ-045 SHALL cover: loop_begin at line 1 with loop_count=3, loop_end at line 2, program_length=4 -> code_index sequence 0,1,2,2,2,3 and loop_level returns to 0.
REQ-046 SHALL cover: jump to line 6 with program_length=4 -> DONE plus an error pulse; write to line 200 with max_code_line=128 -> storage unchanged plus an error pulse.
REQ-047 SHALL cover: loop_depth+1 nested loop_begin pulses -> error on the last one and loop_level==loop_depth.
REQ-048 SHALL cover: reset during the second loop iteration -> IDLE, code_index=0, loop_level=0, with storage contents intact.
